// File: rtl/disparity_pkg.sv
// Geometry, address-width helper and shared types for the disparity pipeline stages.
package disparity_pkg;

    localparam int WIDTH  = 120;
    localparam int HEIGHT = 240;
    localparam int PIX_W  = 21;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic {
        RD_IDLE,
        RD_RUN
    } rd_state_e;

    function automatic int addr_w(input int w, input int h);
        return $clog2(2 * w * h);
    endfunction

endpackage

// File: rtl/bram_wrapper.sv
// Simple dual-port block RAM: one write port, one read port with a registered output.
module bram_wrapper #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/col_major_addr_gen.sv
// Row/column counters for a column-major pixel stream plus the matching raster address,
// stepped incrementally (no multiplier). Address is relative to the start of a frame.
module col_major_addr_gen #(
    parameter int WIDTH  = 4,
    parameter int HEIGHT = 3,
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              adv_i,
    output logic              first_o,
    output logic              last_o,
    output logic [ADDR_W-1:0] addr_o
);

    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              row_end, col_end;

    assign row_end = (row_q == ROW_W'(HEIGHT - 1));
    assign col_end = (col_q == COL_W'(WIDTH - 1));

    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        addr_d = addr_q;
        if (adv_i) begin
            if (row_end && col_end) begin
                row_d  = '0;
                col_d  = '0;
                addr_d = '0;
            end else if (row_end) begin
                // top of the next column sits at raster address col+1
                row_d  = '0;
                col_d  = col_q + COL_W'(1);
                addr_d = ADDR_W'(col_q) + ADDR_W'(1);
            end else begin
                row_d  = row_q + ROW_W'(1);
                addr_d = addr_q + ADDR_W'(WIDTH);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            row_q  <= '0;
            col_q  <= '0;
            addr_q <= '0;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            addr_q <= addr_d;
        end
    end

    assign first_o = (row_q == '0) && (col_q == '0);
    assign last_o  = row_end && col_end;
    assign addr_o  = addr_q;

endmodule

// File: rtl/column_to_raster_buffer.sv
// Ping-pong frame buffer: column-major pixels in, raster-order pixels out.
// Optional out_sof/out_eol/out_eof framing outputs when RASTER_FRAMING_EN is defined.
//   state   | meaning
//   RD_IDLE | waiting for full[rd_bank]
//   RD_RUN  | issuing one read every RD_PERIOD cycles over the bank
module column_to_raster_buffer #(
    parameter int WIDTH      = disparity_pkg::WIDTH,
    parameter int HEIGHT     = disparity_pkg::HEIGHT,
    parameter int DATA_WIDTH = disparity_pkg::PIX_W,
    parameter int RD_PERIOD  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  overflow,
    output logic                  busy
`ifdef RASTER_FRAMING_EN
    ,
    output logic                  out_sof,
    output logic                  out_eol,
    output logic                  out_eof
`endif
);
    import disparity_pkg::*;

    localparam int FRAME = WIDTH * HEIGHT;
    localparam int AW    = addr_w(WIDTH, HEIGHT);
    localparam int THR_W = (RD_PERIOD > 1) ? $clog2(RD_PERIOD) : 1;
    localparam logic [AW-1:0] BANK_OFS  = AW'(FRAME);
    localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME - 1);

    logic          wr_first, wr_last, drop_now, we;
    logic [AW-1:0] wr_addr_rel, waddr, raddr;
    logic          wr_bank_q, wr_bank_d, drop_q, drop_d, overflow_q, overflow_d;
    logic [1:0]    full_q, full_d;

    rd_state_e     state_q, state_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [THR_W-1:0] thr_q, thr_d;
    logic          rd_bank_q, rd_bank_d, issue, rd_done, out_valid_q;

    col_major_addr_gen #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(AW)) u_addr_gen (
        .clk_i   (clk),
        .reset_i (reset),
        .adv_i   (in_valid),
        .first_o (wr_first),
        .last_o  (wr_last),
        .addr_o  (wr_addr_rel)
    );

    // drop is decided once per frame, at its first pixel
    assign drop_now = wr_first ? full_q[wr_bank_q] : drop_q;
    assign we       = in_valid && !drop_now;
    assign waddr    = wr_addr_rel + (wr_bank_q ? BANK_OFS : '0);
    assign raddr    = rd_addr_q + (rd_bank_q ? BANK_OFS : '0);

    always_comb begin
        wr_bank_d  = wr_bank_q;
        drop_d     = drop_q;
        overflow_d = overflow_q;
        full_d     = full_q;
        if (in_valid) begin
            if (wr_first) drop_d = full_q[wr_bank_q];
            if (drop_now) overflow_d = 1'b1;
            if (wr_last && !drop_now) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end
        if (rd_done) full_d[rd_bank_q] = 1'b0;
    end

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        thr_d     = thr_q;
        rd_bank_d = rd_bank_q;
        issue     = 1'b0;
        rd_done   = 1'b0;
        case (state_q)
            RD_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d   = RD_RUN;
                    rd_addr_d = '0;
                    thr_d     = '0;
                end
            end
            RD_RUN: begin
                if (thr_q == '0) begin
                    issue     = 1'b1;
                    thr_d     = THR_W'(RD_PERIOD - 1);
                    rd_addr_d = rd_addr_q + AW'(1);
                    if (rd_addr_q == LAST_ADDR) begin
                        rd_done   = 1'b1;
                        rd_bank_d = ~rd_bank_q;
                        state_d   = RD_IDLE;
                    end
                end else begin
                    thr_d = thr_q - THR_W'(1);
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_bank_q   <= 1'b0;
            drop_q      <= 1'b0;
            overflow_q  <= 1'b0;
            full_q      <= '0;
            state_q     <= RD_IDLE;
            rd_addr_q   <= '0;
            thr_q       <= '0;
            rd_bank_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            drop_q      <= drop_d;
            overflow_q  <= overflow_d;
            full_q      <= full_d;
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            thr_q       <= thr_d;
            rd_bank_q   <= rd_bank_d;
            out_valid_q <= issue;
        end
    end

    bram_wrapper #(.DEPTH(2 * FRAME), .ADDR_W(AW), .DATA_W(DATA_WIDTH)) u_bram (
        .clk_i   (clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (in_data),
        .re_i    (issue),
        .raddr_i (raddr),
        .rdata_o (out_data)
    );

    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;
    assign busy      = (state_q == RD_RUN);

`ifdef RASTER_FRAMING_EN
    localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    logic [COL_W-1:0] rd_col_q;
    logic             sof_q, eol_q, eof_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_col_q <= '0;
            sof_q    <= 1'b0;
            eol_q    <= 1'b0;
            eof_q    <= 1'b0;
        end else begin
            sof_q <= issue && (rd_addr_q == '0);
            eol_q <= issue && (rd_col_q == COL_W'(WIDTH - 1));
            eof_q <= rd_done;
            if (state_q == RD_IDLE) rd_col_q <= '0;
            else if (issue) rd_col_q <= (rd_col_q == COL_W'(WIDTH - 1)) ? '0 : rd_col_q + COL_W'(1);
        end
    end

    assign out_sof = sof_q;
    assign out_eol = eol_q;
    assign out_eof = eof_q;
`endif

endmodule

// File: doc/column_to_raster_buffer.md
Name: column_to_raster_buffer

Overview:
- Inverse of the team's raster-to-column transpose buffer.
- Accepts a column-major pixel stream: column 0 top-to-bottom, then column 1, and so on.
- Stores each frame into one half of a double-buffered (ping-pong) BRAM at its raster address, then streams the completed frame out in row-major order.
- Sits after the column-oriented disparity filtering stages and feeds raster consumers such as the output/VGA path.

Parameters:
- width, 120, pixels per row (number of columns).
- height, 240, pixels per column (number of rows).
- data_width, 21, bits per pixel word.
- rd_period, 1, cycles between output reads; must be >= 1; 1 means one pixel per clock.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  data_width  column-major pixel.
- in_valid  input  1  pixel qualifier; no backpressure, every valid pixel is consumed.
- out_data  output  data_width  row-major pixel.
- out_valid  output  1  output qualifier; no backpressure.
- overflow  output  1  sticky; set when an input frame was discarded.
- busy  output  1  high while the read FSM is in RUN.

Behaviour:
- Reset values: out_valid=0, overflow=0, busy=0, out_data don't-care. Internally: wr_bank=0, rd_bank=0, full[1:0]=0, all counters=0, FSM=IDLE.
- Reset mid-frame abandons all partial writes and reads; the next in_valid pixel is taken as column 0, row 0.
- Memory: one simple dual-port BRAM (via bram_wrapper), depth 2*width*height, 1-cycle registered read. Bank b covers addresses b*frame_size to b*frame_size+frame_size-1.

Write side:
- Counters wr_row (0..height-1) and wr_col (0..width-1). The raster address is maintained incrementally, with no multiplier:
  - addr += width per pixel.
  - At wr_row==height-1: addr = wr_col+1, wr_row=0, wr_col++.
- Drop decision: at the first pixel of a frame (row 0, col 0), latch drop = full[wr_bank].
  - If drop=1: the pixel is not written and overflow <= 1. Counters still advance, so column alignment is kept.
- At the last pixel (row height-1, col width-1), counters return to 0.
  - If not drop: full[wr_bank] <= 1 and wr_bank toggles.
  - If drop: bank state is unchanged.
- A write never targets a full bank, so it never collides with the bank being read.

Read FSM:
- IDLE: when full[rd_bank]=1, go to RUN with rd_addr=0 and throttle counter=0.
- RUN: issue one read every rd_period cycles, rd_addr ascending 0..frame_size-1.
  - out_valid is asserted exactly 1 cycle after each issue, with the corresponding word on out_data.
  - On the cycle the read of frame_size-1 is issued: full[rd_bank] <= 0, rd_bank toggles, return to IDLE.
- Simultaneous set of full[x] by the writer and clear of full[y] by the reader in the same cycle: both take effect; x != y by construction.

Latency:
- Last input pixel accepted in cycle N.
- full is visible in N+1; FSM enters RUN at the N+1 edge.
- First read issued in N+2; first out_valid in N+3.

Arithmetic and widths:
- Addresses use $clog2(2*width*height) bits.
- Bank offset is added combinationally.
- Counters are sized with $clog2 of their range; no wrap beyond the stated limits.

Optional Feature:
- Macro: RASTER_FRAMING_EN.
- With the macro: adds ports out_sof (1 bit, with the pixel at address 0), out_eol (with each pixel where col==width-1) and out_eof (with address frame_size-1). All are qualified by out_valid and reset to 0.
- Without the macro: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package disparity_pkg holds:
  - frame geometry constants (WIDTH=120, HEIGHT=240, PIX_W=21);
  - the function addr_w(w,h) = $clog2(2*w*h);
  - typedef pixel_t.
- The existing bram_wrapper is instantiated as the only sub-module.
- Write-address generation may be split into a sub-module col_major_addr_gen (counters plus incremental address), which is reusable by the forward transpose.

Test Plan:
- width=4, height=3, rd_period=1: input 0..11 column-major -> out_data 0,3,6,9,1,4,7,10,2,5,8,11 on 12 consecutive out_valid cycles, first out_valid 3 cycles after the last in_valid.
- rd_period=4, same frame -> out_valid exactly every 4th cycle, 12 pulses, busy high throughout RUN.
- Three frames back-to-back with in_valid continuously high and rd_period=4 -> frames 1 and 2 output in order; frame 3 dropped (full[0] still set at its start), overflow=1; frame 4 is accepted after the banks drain.
- Reset asserted mid-frame (after 5 pixels), then a full frame -> no out_valid from the partial frame; new frame output correctly; overflow=0.
- Input gaps (in_valid toggling randomly) over a width=120, height=240 frame -> output equals the transpose of the input; busy falls after exactly 28800 outputs.
- RASTER_FRAMING_EN defined, width=4, height=3 -> out_sof with pixel 0, out_eol on outputs 4/8/12, out_eof with the 12th output.
